// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational I-memory address, and a small
// in-order {pc, instr} queue that feeds decode through a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        instr_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  generate
    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
      $error("fetch_unit: DEPTH must be in 2..8");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_unit: RESET_PC must be word aligned");
    end
  endgenerate

  logic [31:0]      pc_q;
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return p + 32'd4;
  endfunction

  assign full          = (count == FULL_CNT);
  assign instr_valid_o = (count != '0);
  assign pop           = instr_valid_o & instr_ready_i;
  assign push          = ~redirect_i & (~full | pop);

  assign pc_addr_o  = pc_q;
  assign instr_o    = q_instr[rd_ptr];
  assign pc_o       = q_pc[rd_ptr];
  assign pc_plus4_o = pc_inc(pc_o);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect_i) begin
      // A same-cycle pop is consumed by decode but leaves no trace here.
      pc_q   <= {redirect_pc_i[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_pc[wr_ptr]    <= pc_q;
        q_instr[wr_ptr] <= instr_i;
        wr_ptr          <= ptr_next(wr_ptr);
        pc_q            <= pc_inc(pc_q);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the CPU. It holds the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction word into a small in-order queue. The queue presents instructions to the decode stage through a valid/ready handshake. Decode or execute can redirect the PC for a branch or jump, which flushes every queued instruction.

## Interface

Parameters:
- RESET_PC, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- DEPTH, default 2: fetch queue entries. Legal range 2..8.

Ports:
- clk_i  input  1: single clock. All state updates on the rising edge.
- rst_i  input  1: reset, asynchronous, active-low. Clears all state immediately when low.
- pc_addr_o  output  32: byte address to instruction memory. Equals the internal PC register.
- instr_i  input  32: instruction word from memory for pc_addr_o, valid in the same cycle (combinational read).
- redirect_i  input  1: load a new PC and flush the queue.
- redirect_pc_i  input  32: target byte address. Bits [1:0] are forced to 0.
- instr_valid_o  output  1: queue head holds a valid instruction.
- instr_o  output  32: instruction word at the queue head.
- pc_o  output  32: byte address of instr_o.
- pc_plus4_o  output  32: pc_o + 4, modulo 2^32.
- instr_ready_i  input  1: decode accepts the head this cycle.

## Operation

- State:
  - PC register.
  - Queue of DEPTH entries {pc, instr} with read pointer, write pointer and count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- pop = instr_valid_o & instr_ready_i.
- push = ~redirect_i & ((count < DEPTH) | pop).
- Priority, evaluated each edge:
  1. Reset.
  2. Redirect: PC <= {redirect_pc_i[31:2], 2'b00}; count, read pointer and write pointer <= 0; no push. A pop in the same cycle counts as consumed but has no further effect on state.
  3. Otherwise:
     - push: write {pc_addr_o, instr_i} at the write pointer, advance it, PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 0).
     - pop: advance the read pointer.
     - count += push - pop.
- Full and no pop: no push. PC holds, so pc_addr_o and the instruction-memory read stay stable.
- Full with pop: push and pop happen together, count unchanged. Full throughput is one instruction per cycle.
- Empty: instr_valid_o = 0. instr_ready_i is ignored, no pop.
- instr_valid_o = (count != 0). instr_o and pc_o come combinationally from the head entry. pc_plus4_o = pc_o + 4.
- Arithmetic: all PC math is 32-bit unsigned, carry discarded.

## Timing

- Reset values while rst_i = 0:
  - PC = RESET_PC, so pc_addr_o = RESET_PC.
  - count = 0, pointers = 0, instr_valid_o = 0.
  - All queue entries cleared, so instr_o = 0, pc_o = 0, pc_plus4_o = 4.
- Reset asserted mid-operation: the queue empties and PC returns to RESET_PC asynchronously, with no wait for a clock edge.
- First fetch: the first rising edge after rst_i rises pushes the word at RESET_PC. instr_valid_o is 1 in the following cycle. Fetch-to-valid latency is 1 cycle.
- Sustained rate with instr_ready_i held at 1: one instruction per cycle. pc_o increments by 4 every cycle.
- Backpressure, instr_ready_i = 0 from cycle k: at most DEPTH further pushes, then the PC freezes. When ready returns, output resumes the next cycle with no lost or duplicated instruction.
- Redirect asserted during cycle N:
  - instr_valid_o = 0 in cycle N+1, with pc_addr_o = target.
  - Target instruction valid in cycle N+2.
  - Redirect held for multiple cycles reloads the PC each cycle and keeps the queue empty.
- Misaligned redirect target: low two bits are dropped silently.

## Test plan

- Reset with RESET_PC=0 and memory word i = i: release reset, hold ready=1 -> instr_valid_o rises 1 cycle later; instr_o/pc_o = 0/0, 1/4, 2/8, … on consecutive cycles; reset values checked beforehand.
- Backpressure with DEPTH=2: drop ready after pc_o=8 -> pc_addr_o freezes at 16, count=2; restore ready 5 cycles later -> pc_o sequence 8, 12, 16, 20 with no gaps or repeats.
- Redirect to 32'h40 while the queue is full and ready=1 -> next cycle valid=0 and pc_addr_o=32'h40; following cycle pc_o=32'h40, instr_o=word 16.
- Misaligned redirect to 32'h43 -> pc_addr_o=32'h40; back-to-back redirects to 32'h10 then 32'h20 -> first valid pc_o=32'h20.
- Wrap: redirect to 32'hFFFF_FFFC -> pc_o=32'hFFFF_FFFC, pc_plus4_o=0, next pc_o=0.
- Async reset pulse mid-stream, between clock edges -> valid=0 and pc_addr_o=RESET_PC immediately; restart matches the first scenario.
